// File: rtl/dffram_port_arbiter_pkg.sv
// Shared types and default sizes for the DFFRAM port arbiter.
package dffram_arb_pkg;

  localparam int unsigned DEF_AW          = 8;
  localparam int unsigned DEF_DW          = 32;
  localparam int unsigned DEF_HK_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } arb_state_e;

  typedef enum logic {
    CPU,
    HK
  } arb_owner_e;

endpackage

// File: rtl/dffram_port_arbiter_if.sv
// CPU port, housekeeping port and DFFRAM pins bundled for the arbiter.
// slave: the arbiter's view. master: requesters plus the RAM macro.
interface dffram_port_arbiter_if
  import dffram_arb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic            cpu_req;
  logic [DW/8-1:0] cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic            cpu_ack;
  logic [DW-1:0]   cpu_rdata;

  logic            hk_req;
  logic [AW-1:0]   hk_addr;
  logic            hk_ack;
  logic [DW-1:0]   hk_rdata;

  logic            ram_en;
  logic [DW/8-1:0] ram_we;
  logic [AW-1:0]   ram_a;
  logic [DW-1:0]   ram_di;
  logic [DW-1:0]   ram_do;

  logic            busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  hk_req, hk_addr,
    output hk_ack, hk_rdata,
    output ram_en, ram_we, ram_a, ram_di,
    input  ram_do,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output hk_req, hk_addr,
    input  hk_ack, hk_rdata,
    input  ram_en, ram_we, ram_a, ram_di,
    output ram_do,
    input  busy
  );

endinterface

// File: rtl/dffram_port_arbiter_wait_ctr.sv
// Saturating count of cycles the housekeeping port has been kept waiting.
module dffram_arb_wait_ctr
  import dffram_arb_pkg::*;
#(
  parameter int unsigned HK_MAX_WAIT = DEF_HK_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic hk_req,
  input  logic hk_owner,
  input  logic hk_win,
  output logic hk_due
);

  // A zero limit still needs a 1-bit register; it simply never counts.
  localparam int unsigned   WW   = (HK_MAX_WAIT > 0) ? $clog2(HK_MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] MAXV = WW'(HK_MAX_WAIT);

  logic [WW-1:0] hk_wait;

  // Count while hk is pending and not being served; clear on win or withdrawal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hk_wait <= '0;
    end else if (hk_win || !hk_req) begin
      hk_wait <= '0;
    end else if (!hk_owner && (hk_wait < MAXV)) begin
      hk_wait <= hk_wait + WW'(1);
    end
  end

  assign hk_due = (hk_wait >= MAXV);

endmodule

// File: rtl/dffram_port_arbiter.sv
// Shares the single-port DFFRAM between the CPU data port and the
// read-only housekeeping port: one access in flight, four cycles each.
module dffram_port_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned HK_MAX_WAIT = DEF_HK_MAX_WAIT
) (
  input  logic                 core_clk,
  input  logic                 core_rst,
  dffram_port_arbiter_if.slave bus
);

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q;
  arb_owner_e      grant_owner;
  logic            grant;
  logic            hk_due;
  logic            acc_rd_q;

  logic            ram_en_q;
  logic [DW/8-1:0] ram_we_q;
  logic [AW-1:0]   ram_a_q;
  logic [DW-1:0]   ram_di_q;
  logic [DW-1:0]   cpu_rdata_q;
  logic [DW-1:0]   hk_rdata_q;

  dffram_arb_wait_ctr #(
    .HK_MAX_WAIT(HK_MAX_WAIT)
  ) u_wait_ctr (
    .clk     (core_clk),
    .rst     (core_rst),
    .hk_req  (bus.hk_req),
    .hk_owner((state_q != IDLE) && (owner_q == HK)),
    .hk_win  (grant && (grant_owner == HK)),
    .hk_due  (hk_due)
  );

  // Access sequencing and winner selection; grants only happen from IDLE.
  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_owner = CPU;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.hk_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
          if (bus.hk_req && (!bus.cpu_req || hk_due)) begin
            grant_owner = HK;
          end
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM pin registers: loaded at the grant edge, enables dropped after ISSUE.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      owner_q  <= CPU;
      acc_rd_q <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= '0;
      ram_a_q  <= '0;
      ram_di_q <= '0;
    end else if (grant) begin
      owner_q  <= grant_owner;
      ram_en_q <= 1'b1;
      if (grant_owner == HK) begin
        acc_rd_q <= 1'b1;
        ram_we_q <= '0;
        ram_a_q  <= bus.hk_addr;
        ram_di_q <= '0;
      end else begin
        acc_rd_q <= (bus.cpu_we == '0);
        ram_we_q <= bus.cpu_we;
        ram_a_q  <= bus.cpu_addr;
        ram_di_q <= bus.cpu_wdata;
      end
    end else if (state_q == ISSUE) begin
      ram_en_q <= 1'b0;
      ram_we_q <= '0;
    end
  end

  // Capture read data for the owner as CAPTURE ends; writes leave rdata alone.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      cpu_rdata_q <= '0;
      hk_rdata_q  <= '0;
    end else if ((state_q == CAPTURE) && acc_rd_q) begin
      if (owner_q == HK) begin
        hk_rdata_q <= bus.ram_do;
      end else begin
        cpu_rdata_q <= bus.ram_do;
      end
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_di    = ram_di_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.hk_rdata  = hk_rdata_q;
  assign bus.cpu_ack   = (state_q == RESP) && (owner_q == CPU);
  assign bus.hk_ack    = (state_q == RESP) && (owner_q == HK);
  assign bus.busy      = (state_q != IDLE);

endmodule
